// File: rtl/cluster_unpacker_if.sv
// Cluster stream in / reconstructed hit map out, grouped as one bus.
// The DUT side is 'slave'; the stream source and map consumer side is 'master'.
interface cluster_unpacker_if #(
    parameter int unsigned NSTRIPS = 1536
);
    logic                 frame_start;
    logic [8*14-1:0]      clusters_in;
    logic [NSTRIPS-1:0]   vpfs_out;
    logic                 frame_valid;
    logic [5:0]           n_clusters;
    logic                 overflow;
    logic                 sync_err;

    modport master (
        output frame_start, clusters_in,
        input  vpfs_out, frame_valid, n_clusters, overflow, sync_err
    );

    modport slave (
        input  frame_start, clusters_in,
        output vpfs_out, frame_valid, n_clusters, overflow, sync_err
    );
endinterface

// File: rtl/cluster_unpacker.sv
// Re-expands an 8-cluster/cycle {cnt,adr} stream into a per-BX strip hit map.
// Accumulates FRAME_LEN cycles per frame and publishes a double-buffered map with a valid pulse.
module cluster_unpacker #(
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned NSTRIPS   = 1536
) (
    input  logic              clock4x,
    input  logic              global_reset,
    cluster_unpacker_if.slave bus
);
    localparam int unsigned NSLOTS = 8;
    localparam int unsigned ADR_W  = 11;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SLOT_W = ADR_W + CNT_W;
    localparam int unsigned PH_W   = 3;
    localparam int unsigned NCL_W  = 6;
    localparam int unsigned DCNT_W = 4;
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(FRAME_LEN - 1);

    typedef enum logic {HUNT, ACCUM} state_e;

    state_e               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [NSTRIPS-1:0]   acc_map_q, acc_map_d;
    logic [NCL_W-1:0]     acc_cnt_q, acc_cnt_d;
    logic                 acc_ovf_q, acc_ovf_d;
    logic [NSTRIPS-1:0]   vpfs_q, vpfs_d;
    logic [NCL_W-1:0]     n_clusters_q, n_clusters_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 sync_err_q, sync_err_d;

    logic [NSTRIPS-1:0]   dec_map;
    logic [DCNT_W-1:0]    dec_cnt;
    logic                 dec_ovf;
    logic [CNT_W-1:0]     slot_cnt;
    logic [ADR_W-1:0]     slot_adr;
    int unsigned          strip;
    logic [NCL_W:0]       sum_cnt;
    logic [NCL_W-1:0]     sat_cnt;

    // Decode one cycle's slots: adr >= NSTRIPS is an empty slot, clusters past the edge are clipped
    always_comb begin
        dec_map  = '0;
        dec_cnt  = '0;
        dec_ovf  = 1'b0;
        slot_cnt = '0;
        slot_adr = '0;
        strip    = 0;
        for (int k = 0; k < NSLOTS; k++) begin
            slot_adr = bus.clusters_in[k*SLOT_W +: ADR_W];
            slot_cnt = bus.clusters_in[k*SLOT_W+ADR_W +: CNT_W];
            if (32'(slot_adr) < NSTRIPS) begin
                dec_cnt = dec_cnt + DCNT_W'(1);
                if (32'(slot_adr) + 32'(slot_cnt) > NSTRIPS - 1) begin
                    dec_ovf = 1'b1;
                end
                for (int j = 0; j < (1 << CNT_W); j++) begin
                    strip = 32'(slot_adr) + 32'(j);
                    if ((CNT_W'(j) <= slot_cnt) && (strip < NSTRIPS)) begin
                        dec_map[ADR_W'(strip)] = 1'b1;
                    end
                end
            end
        end
    end

    // Frame sequencing: hunt for alignment, accumulate, close on last phase or early frame_start
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        acc_map_d     = acc_map_q;
        acc_cnt_d     = acc_cnt_q;
        acc_ovf_d     = acc_ovf_q;
        vpfs_d        = vpfs_q;
        n_clusters_d  = n_clusters_q;
        overflow_d    = overflow_q;
        sync_err_d    = sync_err_q;
        frame_valid_d = 1'b0;

        sum_cnt = (NCL_W+1)'(acc_cnt_q) + (NCL_W+1)'(dec_cnt);
        sat_cnt = (sum_cnt > (NCL_W+1)'(63)) ? NCL_W'(63) : NCL_W'(sum_cnt);

        case (state_q)
            HUNT: begin
                if (bus.frame_start) begin
                    state_d   = ACCUM;
                    phase_d   = PH_W'(1);
                    acc_map_d = dec_map;
                    acc_cnt_d = NCL_W'(dec_cnt);
                    acc_ovf_d = dec_ovf;
                end
            end
            ACCUM: begin
                if (bus.frame_start && (phase_q != '0)) begin
                    // Misaligned start: publish the partial frame, this cycle opens the next one
                    vpfs_d        = acc_map_q;
                    n_clusters_d  = acc_cnt_q;
                    overflow_d    = acc_ovf_q;
                    frame_valid_d = 1'b1;
                    sync_err_d    = 1'b1;
                    acc_map_d     = dec_map;
                    acc_cnt_d     = NCL_W'(dec_cnt);
                    acc_ovf_d     = dec_ovf;
                    phase_d       = PH_W'(1);
                end else if (phase_q == LAST_PH) begin
                    vpfs_d        = acc_map_q | dec_map;
                    n_clusters_d  = sat_cnt;
                    overflow_d    = acc_ovf_q | dec_ovf;
                    frame_valid_d = 1'b1;
                    acc_map_d     = '0;
                    acc_cnt_d     = '0;
                    acc_ovf_d     = 1'b0;
                    phase_d       = '0;
                end else begin
                    acc_map_d = acc_map_q | dec_map;
                    acc_cnt_d = sat_cnt;
                    acc_ovf_d = acc_ovf_q | dec_ovf;
                    phase_d   = phase_q + PH_W'(1);
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            state_q       <= HUNT;
            phase_q       <= '0;
            acc_map_q     <= '0;
            acc_cnt_q     <= '0;
            acc_ovf_q     <= 1'b0;
            vpfs_q        <= '0;
            n_clusters_q  <= '0;
            overflow_q    <= 1'b0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            acc_map_q     <= acc_map_d;
            acc_cnt_q     <= acc_cnt_d;
            acc_ovf_q     <= acc_ovf_d;
            vpfs_q        <= vpfs_d;
            n_clusters_q  <= n_clusters_d;
            overflow_q    <= overflow_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.vpfs_out    = vpfs_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.n_clusters  = n_clusters_q;
    assign bus.overflow    = overflow_q;
    assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
// Directed bench for cluster_unpacker: hand-computed frames, boundaries, misalignment and reset.
module tb_cluster_unpacker;
    localparam int unsigned NSTRIPS = 1536;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   fails;

    logic [111:0]       slots;
    logic [NSTRIPS-1:0] exp_map;

    cluster_unpacker_if #(.NSTRIPS(NSTRIPS)) bus ();

    cluster_unpacker #(.FRAME_LEN(4), .NSTRIPS(NSTRIPS)) dut (
        .clock4x      (clk),
        .global_reset (rst),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [111:0] empty_slots();
        logic [111:0] s;
        for (int k = 0; k < 8; k++) s[k*14 +: 14] = {3'd0, 11'h7FF};
        return s;
    endfunction

    function automatic logic [111:0] put(input logic [111:0] s, input int k,
                                         input logic [2:0] cnt, input logic [10:0] adr);
        logic [111:0] r;
        r = s;
        r[k*14 +: 14] = {cnt, adr};
        return r;
    endfunction

    function automatic logic [NSTRIPS-1:0] set_range(input logic [NSTRIPS-1:0] m,
                                                     input int lo, input int hi);
        logic [NSTRIPS-1:0] r;
        r = m;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step(input logic fs, input logic [111:0] s);
        bus.frame_start = fs;
        bus.clusters_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag, input logic [NSTRIPS-1:0] exp);
        int first;
        first = -1;
        for (int i = NSTRIPS - 1; i >= 0; i--) if (bus.vpfs_out[i] !== exp[i]) first = i;
        total = total + 1;
        assert (bus.vpfs_out === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0d bits set expected %0d bits set, first differing bit %0d",
                   tag, $countones(bus.vpfs_out), $countones(exp), first);
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
        rst    = 1'b1;
        bus.frame_start = 1'b0;
        bus.clusters_in = empty_slots();
        step(1'b0, empty_slots());
        step(1'b1, empty_slots());

        // Reset state
        chk("rst_valid", 32'(bus.frame_valid), 0);
        chk("rst_ncl",   32'(bus.n_clusters), 0);
        chk("rst_ovf",   32'(bus.overflow), 0);
        chk("rst_sync",  32'(bus.sync_err), 0);
        chk_map("rst_map", '0);
        rst = 1'b0;

        // Idle in HUNT: stray clusters without frame_start do nothing
        step(1'b0, put(empty_slots(), 0, 3'd0, 11'd50));
        chk("hunt_valid", 32'(bus.frame_valid), 0);

        // Frame 1: one 3-strip cluster at 100
        step(1'b1, put(empty_slots(), 0, 3'd2, 11'd100));
        step(1'b0, empty_slots());
        step(1'b0, empty_slots());
        chk("f1_early_valid", 32'(bus.frame_valid), 0);
        step(1'b0, empty_slots());
        chk("f1_valid", 32'(bus.frame_valid), 1);
        chk("f1_ncl",   32'(bus.n_clusters), 1);
        chk("f1_ovf",   32'(bus.overflow), 0);
        exp_map = set_range('0, 100, 102);
        chk_map("f1_map", exp_map);

        // Frame 2: cluster clipped at the top strip
        step(1'b1, empty_slots());
        chk("f2_pulse_end", 32'(bus.frame_valid), 0);
        chk_map("f1_hold", exp_map);
        step(1'b0, put(empty_slots(), 3, 3'd7, 11'd1533));
        step(1'b0, empty_slots());
        step(1'b0, empty_slots());
        chk("f2_valid", 32'(bus.frame_valid), 1);
        chk("f2_ncl",   32'(bus.n_clusters), 1);
        chk("f2_ovf",   32'(bus.overflow), 1);
        chk_map("f2_map", set_range('0, 1533, 1535));

        // Frame 3: all 32 slots valid, single strips
        exp_map = '0;
        for (int c = 0; c < 4; c++) begin
            slots = empty_slots();
            for (int k = 0; k < 8; k++) begin
                slots = put(slots, k, 3'd0, 11'(k*8 + c*64));
                exp_map[k*8 + c*64] = 1'b1;
            end
            step(c == 0, slots);
        end
        chk("f3_valid", 32'(bus.frame_valid), 1);
        chk("f3_ncl",   32'(bus.n_clusters), 32);
        chk("f3_ovf",   32'(bus.overflow), 0);
        chk_map("f3_map", exp_map);

        // Frame 4: edge addresses 1535 (valid, no clip) and 1536 (empty slot)
        slots = put(empty_slots(), 1, 3'd0, 11'd1536);
        slots = put(slots, 2, 3'd0, 11'd1535);
        step(1'b1, slots);
        step(1'b0, put(empty_slots(), 0, 3'd0, 11'd5));
        step(1'b0, empty_slots());
        step(1'b0, put(empty_slots(), 7, 3'd1, 11'd1000));
        chk("f4_valid", 32'(bus.frame_valid), 1);
        chk("f4_ncl",   32'(bus.n_clusters), 3);
        chk("f4_ovf",   32'(bus.overflow), 0);
        exp_map = set_range('0, 5, 5);
        exp_map = set_range(exp_map, 1000, 1001);
        exp_map = set_range(exp_map, 1535, 1535);
        chk_map("f4_map", exp_map);

        // Frame 5: frame_start at phase 2 closes a 2-cycle partial frame
        step(1'b1, put(empty_slots(), 0, 3'd1, 11'd200));
        step(1'b0, put(empty_slots(), 0, 3'd0, 11'd300));
        chk("f5_sync_before", 32'(bus.sync_err), 0);
        step(1'b1, put(empty_slots(), 0, 3'd0, 11'd400));
        chk("f5_partial_valid", 32'(bus.frame_valid), 1);
        chk("f5_partial_ncl",   32'(bus.n_clusters), 2);
        chk("f5_sync",          32'(bus.sync_err), 1);
        exp_map = set_range('0, 200, 201);
        exp_map = set_range(exp_map, 300, 300);
        chk_map("f5_partial_map", exp_map);
        step(1'b0, empty_slots());
        chk("f5_no_repeat", 32'(bus.frame_valid), 0);
        step(1'b0, empty_slots());
        step(1'b0, empty_slots());
        chk("f6_valid", 32'(bus.frame_valid), 1);
        chk("f6_ncl",   32'(bus.n_clusters), 1);
        chk("f6_sync_sticky", 32'(bus.sync_err), 1);
        chk_map("f6_map", set_range('0, 400, 400));

        // Reset at phase 2 discards the partial frame
        step(1'b1, put(empty_slots(), 0, 3'd0, 11'd10));
        step(1'b0, empty_slots());
        rst = 1'b1;
        step(1'b0, empty_slots());
        rst = 1'b0;
        chk("mrst_valid", 32'(bus.frame_valid), 0);
        chk("mrst_sync",  32'(bus.sync_err), 0);
        chk("mrst_ncl",   32'(bus.n_clusters), 0);
        chk_map("mrst_map", '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, put(empty_slots(), 0, 3'd0, 11'd10));
            chk("hunt_after_rst", 32'(bus.frame_valid), 0);
        end
        step(1'b1, put(empty_slots(), 4, 3'd0, 11'd20));
        step(1'b0, empty_slots());
        step(1'b0, empty_slots());
        step(1'b0, empty_slots());
        chk("f7_valid", 32'(bus.frame_valid), 1);
        chk("f7_ncl",   32'(bus.n_clusters), 1);
        chk_map("f7_map", set_range('0, 20, 20));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
